control_unit_mc: RTL and testbench

- Parametrised multicycle control FSM for the MIPS-subset datapath. Next generation of the current control unit.
- Drives all datapath mux selects and register enables from opcode/funct, plus ALU status.
- Adds over the current unit: configurable memory wait states, precise overflow and undefined-instruction exceptions with EPC capture, a proper BNE polarity output, JR support, and a sticky halt on BREAK.

---
 rtl/control_unit_mc.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_mc.sv
// control_unit_mc -- multicycle control FSM for the MIPS-subset datapath.
//
// State updates happen on the falling edge of clock; every control output is
// decoded from the current state (Moore), so an asynchronous reset drops all
// strobes (mem_write, reg_write, ...) the moment reset rises.
//
// Parameters
//   MEM_WAIT : idle cycles between address and data valid (0..7), applies
//              to instruction fetch and LW. Each wait state lasts MEM_WAIT+1.
//   STATE_W  : width of state_out (>= 5), state zero-extended.
//
// Optional build macro
//   CTRL_EXC_CAUSE_EN : adds registered exc_cause[1:0]
//                       (01 overflow, 10 undefined opcode, 11 undefined funct).
//
// Ports
//   clock, reset              : clock (falling edge), async active-high reset
//   opcode, funct             : IR[31:26], IR[5:0]
//   overflow, zero            : ALU status (zero is consumed by the datapath
//                               together with pc_write_cond/branch_ne)
//   pc_src .. epc_write       : datapath mux selects and load enables
//   halted                    : high while parked in BREAK
//   state_out                 : current state encoding
//
// State encoding (state_out):
//   0 RESET  1 FETCH  2 FETCH_WAIT  3 IR_LOAD  4 DECODE  5 R_EXEC  6 R_WB
//   7 MEM_ADDR  8 LW_RD  9 LW_WAIT  10 LW_WB  11 SW_WR  12 BRANCH  13 JUMP
//   14 JR  15 LUI  16 EXC  17 BREAK
module control_unit_mc #(
    parameter int MEM_WAIT = 1,
    parameter int STATE_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               overflow,
    input  logic               zero,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_op,
    output logic               reg_write,
    output logic               reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               alu_out_write,
    output logic               a_load,
    output logic               b_load,
    output logic               epc_write,
    output logic               halted,
`ifdef CTRL_EXC_CAUSE_EN
    output logic [1:0]         exc_cause,
`endif
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [4:0] {
        RESET      = 5'd0,
        FETCH      = 5'd1,
        FETCH_WAIT = 5'd2,
        IR_LOAD    = 5'd3,
        DECODE     = 5'd4,
        R_EXEC     = 5'd5,
        R_WB       = 5'd6,
        MEM_ADDR   = 5'd7,
        LW_RD      = 5'd8,
        LW_WAIT    = 5'd9,
        LW_WB      = 5'd10,
        SW_WR      = 5'd11,
        BRANCH     = 5'd12,
        JUMP       = 5'd13,
        JR         = 5'd14,
        LUI        = 5'd15,
        EXC        = 5'd16,
        BREAK      = 5'd17
    } state_t;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOP  = 6'b000000;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_BRK  = 6'b001101;

    state_t     state, nxt;
    logic [2:0] wcnt;
    logic       bne_q;

    // zero is used by the datapath branch logic, not by the sequencer
    logic unused_zero;
    assign unused_zero = zero;

    assign state_out = STATE_W'(state);

    // The wait counter is loaded on entry to a wait state, so the state is
    // held MEM_WAIT extra cycles beyond its first one.
    wire enter_wait = (nxt == FETCH_WAIT && state != FETCH_WAIT) ||
                      (nxt == LW_WAIT    && state != LW_WAIT);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state <= RESET;
            wcnt  <= 3'd0;
            bne_q <= 1'b0;
        end else begin
            state <= nxt;
            if (enter_wait)
                wcnt <= 3'(MEM_WAIT);
            else if (wcnt != 3'd0)
                wcnt <= wcnt - 3'd1;
            // branch polarity is captured at dispatch and replayed in BRANCH
            if (state == DECODE)
                bne_q <= (opcode == OP_BNE);
        end
    end

    always_comb begin
        nxt           = state;
        pc_src        = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 2'b00;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        alu_out_write = 1'b0;
        a_load        = 1'b0;
        b_load        = 1'b0;
        epc_write     = 1'b0;
        halted        = 1'b0;
        case (state)
            RESET: nxt = FETCH;
            FETCH: begin
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                pc_write  = 1'b1;
                nxt       = FETCH_WAIT;
            end
            FETCH_WAIT: if (wcnt == 3'd0) nxt = IR_LOAD;
            IR_LOAD: begin
                ir_write = 1'b1;
                nxt      = DECODE;
            end
            DECODE: begin
                a_load        = 1'b1;
                b_load        = 1'b1;
                alu_src_b     = 2'b11;
                alu_op        = 3'b001;
                alu_out_write = 1'b1;
                case (opcode)
                    OP_R: begin
                        case (funct)
                            F_ADD, F_SUB, F_AND, F_XOR: nxt = R_EXEC;
                            F_NOP:   nxt = FETCH;
                            F_JR:    nxt = JR;
                            F_BRK:   nxt = BREAK;
                            default: nxt = EXC;
                        endcase
                    end
                    OP_LW, OP_SW:   nxt = MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt = BRANCH;
                    OP_LUI:         nxt = LUI;
                    OP_J:           nxt = JUMP;
                    default:        nxt = EXC;
                endcase
            end
            R_EXEC: begin
                alu_src_a     = 1'b1;
                alu_out_write = 1'b1;
                case (funct)
                    F_ADD:   alu_op = 3'b001;
                    F_SUB:   alu_op = 3'b010;
                    F_AND:   alu_op = 3'b011;
                    F_XOR:   alu_op = 3'b110;
                    default: alu_op = 3'b000;
                endcase
                // only signed add/sub trap; logical ops never overflow
                if ((funct == F_ADD || funct == F_SUB) && overflow)
                    nxt = EXC;
                else
                    nxt = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt       = FETCH;
            end
            MEM_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_op        = 3'b001;
                alu_out_write = 1'b1;
                nxt           = (opcode == OP_LW) ? LW_RD : SW_WR;
            end
            LW_RD: begin
                iord = 1'b1;
                nxt  = LW_WAIT;
            end
            LW_WAIT: begin
                iord = 1'b1;
                if (wcnt == 3'd0) nxt = LW_WB;
            end
            LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                nxt        = FETCH;
            end
            SW_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b010;
                pc_src        = 2'b01;
                pc_write_cond = 1'b1;
                branch_ne     = bne_q;
                nxt           = FETCH;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                nxt      = FETCH;
            end
            JR: begin
                alu_src_a = 1'b1;
                pc_write  = 1'b1;
                nxt       = FETCH;
            end
            LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                nxt        = FETCH;
            end
            EXC: begin
                epc_write = 1'b1;
                pc_src    = 2'b11;
                pc_write  = 1'b1;
                nxt       = FETCH;
            end
            BREAK: begin
                halted = 1'b1;
                nxt    = BREAK;
            end
            default: nxt = RESET;
        endcase
    end

`ifdef CTRL_EXC_CAUSE_EN
    logic [1:0] cause_nxt;

    // Cause of the exception being entered; only meaningful when nxt==EXC.
    always_comb begin
        cause_nxt = 2'b00;
        if (state == R_EXEC)
            cause_nxt = 2'b01;
        else if (state == DECODE)
            cause_nxt = (opcode == OP_R) ? 2'b11 : 2'b10;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset)
            exc_cause <= 2'b00;
        else if (nxt == EXC && state != EXC)
            exc_cause <= cause_nxt;
    end
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc. Three instances (MEM_WAIT = 1, 3, 0)
// share the inputs; expected state/control pairs are queued as each
// instruction is driven and popped one per rising edge (the DUT moves on the
// falling edge, so outputs are stable when sampled).
module tb_control_unit_mc;

    localparam logic [4:0] S_RESET = 5'd0,  S_FETCH = 5'd1,  S_FW = 5'd2,
                           S_IRL = 5'd3,    S_DEC = 5'd4,    S_REX = 5'd5,
                           S_RWB = 5'd6,    S_MA = 5'd7,     S_LRD = 5'd8,
                           S_LWT = 5'd9,    S_LWB = 5'd10,   S_SW = 5'd11,
                           S_BR = 5'd12,    S_J = 5'd13,     S_JR = 5'd14,
                           S_LUI = 5'd15,   S_EXC = 5'd16,   S_BRK = 5'd17;

    typedef struct packed {
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] mem_to_reg;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       alu_out_write;
        logic       a_load;
        logic       b_load;
        logic       epc_write;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        logic [4:0] st;
        ctl_t       ctl;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       overflow, zero;
    ctl_t       c1, c3, c0;
    logic [4:0] s1, s3, s0;
`ifdef CTRL_EXC_CAUSE_EN
    logic [1:0] ec1, ec3, ec0;
`endif

    exp_t q[$];
    int   sel;
    int   n_tot  = 0;
    int   n_pass = 0;

    always #5 clock = ~clock;

    control_unit_mc #(.MEM_WAIT(1)) d1 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .pc_src(c1.pc_src), .alu_src_a(c1.alu_src_a), .alu_src_b(c1.alu_src_b),
        .alu_op(c1.alu_op), .reg_write(c1.reg_write), .reg_dst(c1.reg_dst),
        .mem_to_reg(c1.mem_to_reg), .mem_write(c1.mem_write), .iord(c1.iord),
        .ir_write(c1.ir_write), .pc_write(c1.pc_write),
        .pc_write_cond(c1.pc_write_cond), .branch_ne(c1.branch_ne),
        .alu_out_write(c1.alu_out_write), .a_load(c1.a_load), .b_load(c1.b_load),
        .epc_write(c1.epc_write), .halted(c1.halted),
`ifdef CTRL_EXC_CAUSE_EN
        .exc_cause(ec1),
`endif
        .state_out(s1));

    control_unit_mc #(.MEM_WAIT(3)) d3 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .pc_src(c3.pc_src), .alu_src_a(c3.alu_src_a), .alu_src_b(c3.alu_src_b),
        .alu_op(c3.alu_op), .reg_write(c3.reg_write), .reg_dst(c3.reg_dst),
        .mem_to_reg(c3.mem_to_reg), .mem_write(c3.mem_write), .iord(c3.iord),
        .ir_write(c3.ir_write), .pc_write(c3.pc_write),
        .pc_write_cond(c3.pc_write_cond), .branch_ne(c3.branch_ne),
        .alu_out_write(c3.alu_out_write), .a_load(c3.a_load), .b_load(c3.b_load),
        .epc_write(c3.epc_write), .halted(c3.halted),
`ifdef CTRL_EXC_CAUSE_EN
        .exc_cause(ec3),
`endif
        .state_out(s3));

    control_unit_mc #(.MEM_WAIT(0)) d0 (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
        .overflow(overflow), .zero(zero),
        .pc_src(c0.pc_src), .alu_src_a(c0.alu_src_a), .alu_src_b(c0.alu_src_b),
        .alu_op(c0.alu_op), .reg_write(c0.reg_write), .reg_dst(c0.reg_dst),
        .mem_to_reg(c0.mem_to_reg), .mem_write(c0.mem_write), .iord(c0.iord),
        .ir_write(c0.ir_write), .pc_write(c0.pc_write),
        .pc_write_cond(c0.pc_write_cond), .branch_ne(c0.branch_ne),
        .alu_out_write(c0.alu_out_write), .a_load(c0.a_load), .b_load(c0.b_load),
        .epc_write(c0.epc_write), .halted(c0.halted),
`ifdef CTRL_EXC_CAUSE_EN
        .exc_cause(ec0),
`endif
        .state_out(s0));

    // Control word each state must produce, straight from the state table.
    function automatic ctl_t ectl(input logic [4:0] s, input logic [2:0] op,
                                  input logic bne);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin c.alu_src_b = 2'b01; c.alu_op = 3'b001; c.pc_write = 1'b1; end
            S_IRL:   c.ir_write = 1'b1;
            S_DEC: begin
                c.a_load = 1'b1; c.b_load = 1'b1; c.alu_src_b = 2'b11;
                c.alu_op = 3'b001; c.alu_out_write = 1'b1;
            end
            S_REX:   begin c.alu_src_a = 1'b1; c.alu_op = op; c.alu_out_write = 1'b1; end
            S_RWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_MA: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b001;
                c.alu_out_write = 1'b1;
            end
            S_LRD, S_LWT: c.iord = 1'b1;
            S_LWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_SW:    begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_BR: begin
                c.alu_src_a = 1'b1; c.alu_op = 3'b010; c.pc_src = 2'b01;
                c.pc_write_cond = 1'b1; c.branch_ne = bne;
            end
            S_J:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            S_JR:    begin c.alu_src_a = 1'b1; c.pc_write = 1'b1; end
            S_LUI:   begin c.reg_write = 1'b1; c.mem_to_reg = 2'b10; end
            S_EXC:   begin c.epc_write = 1'b1; c.pc_src = 2'b11; c.pc_write = 1'b1; end
            S_BRK:   c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    task automatic push(input logic [4:0] s, input logic [2:0] op = 3'b000,
                        input logic bne = 1'b0);
        exp_t e;
        e.st  = s;
        e.ctl = ectl(s, op, bne);
        q.push_back(e);
    endtask

    // FETCH_WAIT for mw+1 cycles, then IR_LOAD and DECODE
    task automatic push_fetch(input int mw);
        for (int i = 0; i <= mw; i++) push(S_FW);
        push(S_IRL);
        push(S_DEC);
    endtask

    function automatic exp_t sample(input int which);
        exp_t o;
        case (which)
            3:       begin o.st = s3; o.ctl = c3; end
            0:       begin o.st = s0; o.ctl = c0; end
            default: begin o.st = s1; o.ctl = c1; end
        endcase
        return o;
    endfunction

    // One expected entry per rising edge; bounded by the queue length.
    task automatic drain(input string name);
        exp_t e, o;
        int   k;
        k = 0;
        while (q.size() > 0) begin
            @(posedge clock);
            e = q.pop_front();
            o = sample(sel);
            chk($sformatf("%s[%0d].state", name, k), 32'(o.st), 32'(e.st));
            chk($sformatf("%s[%0d].ctl", name, k), 32'(o.ctl), 32'(e.ctl));
            k++;
        end
    endtask

    // Hold reset across a falling edge, check RESET outputs, release.
    task automatic rst();
        exp_t o;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        o = sample(sel);
        chk("reset.state", 32'(o.st), 32'(S_RESET));
        chk("reset.ctl", 32'(o.ctl), 32'd0);
        #1 reset = 1'b0;
    endtask

    task automatic setop(input logic [5:0] op, input logic [5:0] fn, input logic ov);
        opcode   = op;
        funct    = fn;
        overflow = ov;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        sel   = 1;
        setop(6'b000000, 6'b100000, 1'b0);   // add
        rst();
`ifdef CTRL_EXC_CAUSE_EN
        chk("exc_cause.reset", 32'(ec1), 32'd0);
`endif
        push(S_FETCH); push_fetch(1); push(S_REX, 3'b001); push(S_RWB); push(S_FETCH);
        drain("add");

        setop(6'b000000, 6'b100010, 1'b1);   // sub with overflow
        push_fetch(1); push(S_REX, 3'b010); push(S_EXC); push(S_FETCH);
        drain("sub_ovf");
`ifdef CTRL_EXC_CAUSE_EN
        chk("exc_cause.ovf", 32'(ec1), 32'd1);
`endif

        setop(6'b000000, 6'b100110, 1'b0);   // xor
        push_fetch(1); push(S_REX, 3'b110); push(S_RWB); push(S_FETCH);
        drain("xor");

        setop(6'b000000, 6'b100100, 1'b1);   // and ignores overflow
        push_fetch(1); push(S_REX, 3'b011); push(S_RWB); push(S_FETCH);
        drain("and_ovf");

        setop(6'b000101, 6'b000000, 1'b0);   // bne
        push_fetch(1); push(S_BR, 3'b000, 1'b1); push(S_FETCH);
        drain("bne");

        setop(6'b000100, 6'b000000, 1'b0);   // beq
        push_fetch(1); push(S_BR, 3'b000, 1'b0); push(S_FETCH);
        drain("beq");

        setop(6'b001111, 6'b000000, 1'b0);   // lui
        push_fetch(1); push(S_LUI); push(S_FETCH);
        drain("lui");

        setop(6'b000010, 6'b000000, 1'b0);   // j
        push_fetch(1); push(S_J); push(S_FETCH);
        drain("j");

        setop(6'b000000, 6'b001000, 1'b0);   // jr
        push_fetch(1); push(S_JR); push(S_FETCH);
        drain("jr");

        setop(6'b000000, 6'b000000, 1'b0);   // nop
        push_fetch(1); push(S_FETCH);
        drain("nop");

        setop(6'b111111, 6'b000000, 1'b0);   // undefined opcode
        push_fetch(1); push(S_EXC); push(S_FETCH);
        drain("bad_op");
`ifdef CTRL_EXC_CAUSE_EN
        chk("exc_cause.op", 32'(ec1), 32'd2);
`endif

        setop(6'b000000, 6'b111111, 1'b0);   // undefined funct
        push_fetch(1); push(S_EXC); push(S_FETCH);
        drain("bad_fn");
`ifdef CTRL_EXC_CAUSE_EN
        chk("exc_cause.fn", 32'(ec1), 32'd3);
`endif

        setop(6'b101011, 6'b000000, 1'b0);   // sw, reset while writing
        push_fetch(1); push(S_MA); push(S_SW);
        drain("sw");
        #1 reset = 1'b1;
        #1;
        chk("sw_rst.mem_write", 32'(c1.mem_write), 32'd0);
        chk("sw_rst.state", 32'(s1), 32'(S_RESET));

        setop(6'b100011, 6'b000000, 1'b0);   // lw, MEM_WAIT=3
        sel = 3;
        rst();
        push(S_FETCH); push_fetch(3); push(S_MA); push(S_LRD);
        repeat (4) push(S_LWT);
        push(S_LWB); push(S_FETCH);
        drain("lw_w3");

        sel = 0;                             // lw, MEM_WAIT=0
        rst();
        push(S_FETCH); push_fetch(0); push(S_MA); push(S_LRD); push(S_LWT);
        push(S_LWB); push(S_FETCH);
        drain("lw_w0");

        sel = 1;                             // break, sticky halt
        setop(6'b000000, 6'b001101, 1'b0);
        rst();
        push(S_FETCH); push_fetch(1);
        repeat (21) push(S_BRK);
        drain("break");
        #1 reset = 1'b1;
        #1;
        chk("brk_rst.halted", 32'(c1.halted), 32'd0);
        chk("brk_rst.state", 32'(s1), 32'(S_RESET));
`ifdef CTRL_EXC_CAUSE_EN
        chk("brk_rst.exc_cause", 32'(ec1), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
